// File: rtl/c2sif_arb.sv
// Round-robin arbiter that runs one 4-phase req/ack c2sif transaction at a time on a shared bus.
// Optional ack timeout: define C2SIF_ARB_TIMEOUT_EN.
module c2sif_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned IDW       = 8,
  parameter int unsigned FNW       = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     m_req,
  input  logic [N*IDW-1:0] m_id,
  input  logic [N*FNW-1:0] m_fn,
  input  logic [N*DW-1:0]  m_data,
  output logic [N-1:0]     m_gnt,
  output logic [N-1:0]     m_done,
  output logic [DW-1:0]    m_ret,
  output logic             m_err,
  output logic             bus_req,
  output logic [IDW-1:0]   bus_id,
  output logic [FNW-1:0]   bus_fn,
  output logic [DW-1:0]    bus_data,
  input  logic             bus_ack,
  input  logic [DW-1:0]    bus_ret
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || N > 16 || TO_CYCLES < 1) begin : g_param_check
    $error("c2sif_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic            ack_meta, ack_s;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            bus_req_nxt;
  logic [IDW-1:0]  bus_id_nxt;
  logic [FNW-1:0]  bus_fn_nxt;
  logic [DW-1:0]   bus_data_nxt;
  logic [N-1:0]    m_gnt_nxt, m_done_nxt;
  logic [DW-1:0]   m_ret_nxt;

`ifdef C2SIF_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          m_err_nxt;
`else
  assign m_err = 1'b0;
`endif

  // Synchronizer resets high so a stale ack present at reset release is never mistaken for idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b1;
      ack_s    <= 1'b1;
    end else begin
      ack_meta <= bus_ack;
      ack_s    <= ack_meta;
    end
  end

  // First requester above ptr, wrapping; descending loop lets the nearest one win.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = int'(N); k >= 1; k--) begin
      j = (int'(ptr) + k) % int'(N);
      if (m_req[j]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PW'(N - 1);
      bus_req  <= 1'b0;
      bus_id   <= '0;
      bus_fn   <= '0;
      bus_data <= '0;
      m_gnt    <= '0;
      m_done   <= '0;
      m_ret    <= '0;
`ifdef C2SIF_ARB_TIMEOUT_EN
      cnt      <= '0;
      m_err    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      bus_req  <= bus_req_nxt;
      bus_id   <= bus_id_nxt;
      bus_fn   <= bus_fn_nxt;
      bus_data <= bus_data_nxt;
      m_gnt    <= m_gnt_nxt;
      m_done   <= m_done_nxt;
      m_ret    <= m_ret_nxt;
`ifdef C2SIF_ARB_TIMEOUT_EN
      cnt      <= cnt_nxt;
      m_err    <= m_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    bus_req_nxt  = bus_req;
    bus_id_nxt   = bus_id;
    bus_fn_nxt   = bus_fn;
    bus_data_nxt = bus_data;
    m_gnt_nxt    = m_gnt;
    m_done_nxt   = '0;
    m_ret_nxt    = m_ret;
`ifdef C2SIF_ARB_TIMEOUT_EN
    cnt_nxt      = cnt;
    m_err_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (pick_found && !ack_s) begin
          bus_id_nxt          = m_id[pick_idx*IDW +: IDW];
          bus_fn_nxt          = m_fn[pick_idx*FNW +: FNW];
          bus_data_nxt        = m_data[pick_idx*DW +: DW];
          m_gnt_nxt           = '0;
          m_gnt_nxt[pick_idx] = 1'b1;
          ptr_nxt             = pick_idx;
          bus_req_nxt         = 1'b1;
          state_nxt           = REQ;
`ifdef C2SIF_ARB_TIMEOUT_EN
          cnt_nxt             = '0;
`endif
        end
      end
      REQ: begin
        if (ack_s) begin
          m_ret_nxt   = bus_ret;
          bus_req_nxt = 1'b0;
          state_nxt   = REL;
        end
`ifdef C2SIF_ARB_TIMEOUT_EN
        else if (cnt == CW'(TO_CYCLES - 1)) begin
          m_ret_nxt   = '1;
          bus_req_nxt = 1'b0;
          m_err_nxt   = 1'b1;
          m_done_nxt  = m_gnt;
          m_gnt_nxt   = '0;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      REL: begin
        if (!ack_s) begin
          m_done_nxt = m_gnt;
          m_gnt_nxt  = '0;
          state_nxt  = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
